// File: rtl/input_stage_pipe_if.sv
// Handshake and data bundle for the beamformer input register stage.
// The upstream/downstream driver uses master; the stage itself uses slave.
interface input_stage_pipe_if #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DW    = 18,
    parameter int unsigned CNT_W = 16
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [N_CH*2*DW-1:0]     xin;
    logic [2*DW-1:0]          din;
    logic                     w_load;
    logic [N_CH*2*DW-1:0]     win;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_CH*2*DW-1:0]     x;
    logic [2*DW-1:0]          d;
    logic [N_CH*2*DW-1:0]     w;
    logic                     w_new;
    logic [CNT_W-1:0]         sample_cnt;

    modport master (
        output in_valid, xin, din, w_load, win, out_ready,
        input  in_ready, out_valid, x, d, w, w_new, sample_cnt
    );

    modport slave (
        input  in_valid, xin, din, w_load, win, out_ready,
        output in_ready, out_valid, x, d, w, w_new, sample_cnt
    );
endinterface

// File: rtl/input_stage_pipe.sv
// Input register stage for the adaptive beamformer: pipes snapshot x, reference d and
// the weight set in force at accept time through DEPTH stages with valid/ready control.
module input_stage_pipe #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DW    = 18,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    input_stage_pipe_if.slave bus
);
    localparam int unsigned XW  = N_CH * 2 * DW;
    localparam int unsigned DDW = 2 * DW;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XW-1:0]    r_x   [DEPTH];
    logic [DDW-1:0]   r_d   [DEPTH];
    logic [XW-1:0]    r_w   [DEPTH];
    logic             r_new [DEPTH];
    logic             r_vld [DEPTH];

    logic [XW-1:0]    r_w_shadow;
    logic             r_load_flag;
    logic [CNT_W-1:0] r_cnt;

    logic             w_adv;
    logic             w_accept;
    logic             w_out_hs;

    // Whole pipe moves in lockstep: bubbles are not collapsed.
    assign w_adv    = !r_vld[DEPTH-1] || bus.out_ready;
    assign w_accept = bus.in_valid && w_adv;
    assign w_out_hs = r_vld[DEPTH-1] && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_vld[i] <= 1'b0;
                r_x[i]   <= '0;
                r_d[i]   <= '0;
                r_w[i]   <= '0;
                r_new[i] <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld[0] <= bus.in_valid;
            r_x[0]   <= bus.xin;
            r_d[0]   <= bus.din;
            r_w[0]   <= r_w_shadow;
            r_new[0] <= r_load_flag;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_x[i]   <= r_x[i-1];
                r_d[i]   <= r_d[i-1];
                r_w[i]   <= r_w[i-1];
                r_new[i] <= r_new[i-1];
            end
        end
    end

    // A sample accepted alongside a load still sees the old shadow and flag,
    // and the flag survives so the following sample is marked as first-new.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_shadow  <= '0;
            r_load_flag <= 1'b0;
        end else if (bus.w_load) begin
            r_w_shadow  <= bus.win;
            r_load_flag <= 1'b1;
        end else if (w_accept) begin
            r_load_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_out_hs) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign bus.in_ready   = w_adv;
    assign bus.out_valid  = r_vld[DEPTH-1];
    assign bus.x          = r_x[DEPTH-1];
    assign bus.d          = r_d[DEPTH-1];
    assign bus.w          = r_w[DEPTH-1];
    assign bus.w_new      = r_new[DEPTH-1];
    assign bus.sample_cnt = r_cnt;
endmodule

// File: tb/tb_input_stage_pipe.sv
// Directed bench for input_stage_pipe: a DEPTH=1/CNT_W=4 instance and a DEPTH=3 instance.
module tb_input_stage_pipe;
    localparam int N_CH = 8;
    localparam int DW   = 18;
    localparam int XW   = N_CH * 2 * DW;
    localparam int DDW  = 2 * DW;

    typedef logic [XW-1:0] val_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    input_stage_pipe_if #(.N_CH(N_CH), .DW(DW), .CNT_W(4))  ifa ();
    input_stage_pipe_if #(.N_CH(N_CH), .DW(DW), .CNT_W(16)) ifb ();

    input_stage_pipe #(.N_CH(N_CH), .DW(DW), .DEPTH(1), .CNT_W(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    input_stage_pipe #(.N_CH(N_CH), .DW(DW), .DEPTH(3), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    task automatic check(input string tag, input val_t obs, input val_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel-1 I component carries the sample tag.
    function automatic val_t mk_x(input int v);
        val_t t;
        t = '0;
        t[XW-1 -: DW] = DW'(v);
        return t;
    endfunction

    initial begin
        val_t             q[$];
        val_t             prev_x;
        logic             prev_stall;
        int               nxt;
        logic [DDW-1:0]   ext;
        val_t             xe;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.in_valid = 1'b0; ifa.xin = '0; ifa.din = '0; ifa.w_load = 1'b0; ifa.win = '0;
        ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.xin = '0; ifb.din = '0; ifb.w_load = 1'b0; ifb.win = '0;
        ifb.out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", val_t'(ifa.out_valid), val_t'(0));
        check("rst_in_ready", val_t'(ifa.in_ready), val_t'(1));
        check("rst_cnt", val_t'(ifa.sample_cnt), val_t'(0));
        check("rst_x", ifa.x, val_t'(0));
        check("rst_w_new", val_t'(ifa.w_new), val_t'(0));
        rst_a = 1'b0;

        // 1: stream of 8 through DEPTH=1
        for (int i = 1; i <= 8; i++) begin
            ifa.in_valid = 1'b1;
            ifa.xin      = mk_x(i);
            ifa.din      = DDW'(i);
            tick();
            check("t1_valid", val_t'(ifa.out_valid), val_t'(1));
            check("t1_x", ifa.x, mk_x(i));
            check("t1_d", val_t'(ifa.d), val_t'(i));
        end
        ifa.in_valid = 1'b0;
        tick();
        check("t1_cnt", val_t'(ifa.sample_cnt), val_t'(8));
        check("t1_idle", val_t'(ifa.out_valid), val_t'(0));

        // 3: load on the same edge as sample A
        ifa.in_valid = 1'b1;
        ifa.xin      = mk_x('hA);
        ifa.w_load   = 1'b1;
        ifa.win      = val_t'(1);
        tick();
        check("t3_a_x", ifa.x, mk_x('hA));
        check("t3_a_w", ifa.w, val_t'(0));
        check("t3_a_new", val_t'(ifa.w_new), val_t'(0));
        ifa.w_load = 1'b0;
        ifa.xin    = mk_x('hB);
        tick();
        check("t3_b_w", ifa.w, val_t'(1));
        check("t3_b_new", val_t'(ifa.w_new), val_t'(1));
        ifa.in_valid = 1'b0;
        tick();

        // 4: two loads, no accept between
        ifa.w_load = 1'b1;
        ifa.win    = val_t'(5);
        tick();
        ifa.win    = val_t'(9);
        tick();
        ifa.w_load   = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.xin      = mk_x('hC);
        tick();
        check("t4_c_w", ifa.w, val_t'(9));
        check("t4_c_new", val_t'(ifa.w_new), val_t'(1));
        ifa.xin = mk_x('hD);
        tick();
        check("t4_d_w", ifa.w, val_t'(9));
        check("t4_d_new", val_t'(ifa.w_new), val_t'(0));
        ifa.in_valid = 1'b0;
        tick();
        check("t4_cnt", val_t'(ifa.sample_cnt), val_t'(12));

        // 6a: signed extremes pass through bit-exact
        ext = {1'b1, {(DW-1){1'b0}}, 1'b0, {(DW-1){1'b1}}};
        xe  = {N_CH{ext}};
        ifa.in_valid = 1'b1;
        ifa.xin      = xe;
        ifa.din      = ext;
        tick();
        check("t6_ext_x", ifa.x, xe);
        check("t6_ext_d", val_t'(ifa.d), val_t'(ext));
        ifa.in_valid = 1'b0;
        tick();

        // 6b: 17 handshakes on a 4-bit counter
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("t6_cnt_rst", val_t'(ifa.sample_cnt), val_t'(0));
        for (int i = 0; i < 17; i++) begin
            ifa.in_valid = 1'b1;
            ifa.xin      = mk_x(100 + i);
            tick();
            check("t6_x", ifa.x, mk_x(100 + i));
        end
        ifa.in_valid = 1'b0;
        tick();
        check("t6_wrap", val_t'(ifa.sample_cnt), val_t'(1));

        // 2: DEPTH=3 with a 5-cycle stall mid-stream
        rst_b = 1'b0;
        nxt        = 1;
        prev_stall = 1'b0;
        prev_x     = '0;
        for (int c = 0; c < 20; c++) begin
            ifb.out_ready = !(c >= 8 && c < 13);
            ifb.in_valid  = 1'b1;
            ifb.xin       = mk_x(nxt);
            ifb.din       = DDW'(nxt);
            #1;
            if (c == 2) check("t2_lat_lo", val_t'(ifb.out_valid), val_t'(0));
            if (c == 3) check("t2_lat_hi", val_t'(ifb.out_valid), val_t'(1));
            if (prev_stall) check("t2_hold", ifb.x, prev_x);
            if (c >= 8 && c < 13) check("t2_in_ready", val_t'(ifb.in_ready), val_t'(0));
            if (ifb.out_valid && ifb.out_ready) begin
                if (q.size() == 0) check("t2_extra", val_t'(q.size()), val_t'(1));
                else check("t2_order", ifb.x, q.pop_front());
            end
            if (ifb.in_valid && ifb.in_ready) begin
                q.push_back(mk_x(nxt));
                nxt++;
            end
            prev_stall = ifb.out_valid && !ifb.out_ready;
            prev_x     = ifb.x;
            tick();
        end
        ifb.in_valid  = 1'b0;
        ifb.out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (ifb.out_valid) check("t2_drain", ifb.x, q.pop_front());
            tick();
        end
        check("t2_drained", val_t'(q.size()), val_t'(0));
        check("t2_cnt", val_t'(ifb.sample_cnt), val_t'(nxt - 1));

        // 5: reset with the pipe full and stalled
        ifb.out_ready = 1'b0;
        ifb.in_valid  = 1'b1;
        ifb.w_load    = 1'b1;
        ifb.win       = val_t'('h77);
        for (int c = 0; c < 4; c++) begin
            ifb.xin = mk_x(200 + c);
            tick();
        end
        ifb.w_load = 1'b0;
        check("t5_full", val_t'(ifb.in_ready), val_t'(0));
        rst_b = 1'b1;
        tick();
        check("t5_valid", val_t'(ifb.out_valid), val_t'(0));
        check("t5_x", ifb.x, val_t'(0));
        check("t5_d", val_t'(ifb.d), val_t'(0));
        check("t5_w", ifb.w, val_t'(0));
        check("t5_w_new", val_t'(ifb.w_new), val_t'(0));
        check("t5_cnt", val_t'(ifb.sample_cnt), val_t'(0));
        rst_b = 1'b0;
        ifb.out_ready = 1'b1;
        ifb.xin       = mk_x(300);
        tick();
        ifb.in_valid = 1'b0;
        tick();
        tick();
        check("t5_post_valid", val_t'(ifb.out_valid), val_t'(1));
        check("t5_post_x", ifb.x, mk_x(300));
        check("t5_shadow", ifb.w, val_t'(0));
        check("t5_flag", val_t'(ifb.w_new), val_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
